uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 8680, the maximum ipClk cycles allowed between consecutive frame bytes.
REQ-003 ipClk  in  1  clock; all logic SHALL be rising-edge.
REQ-004 Reset  in  1  reset, synchronous, active-high.
REQ-005 ipRxData  in  8  received byte from the UART receiver.
REQ-006 ipRxValid  in  1  byte-valid level, which may stay high for many cycles.
REQ-007 opTxData  out  8  response byte to the UART transmitter.
REQ-008 opTxSend  out  1  transmit request level.
REQ-009 ipTxBusy  in  1  transmitter busy.
REQ-010 opRegAddr  out  7  register address.
REQ-011 opRegWrData  out  16  register write data.
REQ-012 opRegWe  out  1  one-cycle write strobe.
REQ-013 opRegRe / ipRegRdData  out 1 / in 16  read strobe and read data; present only with CMD_DECODER_READBACK_EN.

Function
REQ-014 A byte SHALL be accepted only on the cycle after a 0->1 transition of ipRxValid, so each held-high valid counts as exactly one byte.
REQ-015 Frame format: SYNC, CMD, DHI, DLO, CSUM, where CMD[6:0] is the address and CMD[7] is 1 for read, 0 for write.
REQ-016 CSUM SHALL equal CMD ^ DHI ^ DLO.
REQ-017 Decoder states SHALL be IDLE -> CMD -> DHI -> DLO -> CSUM -> EXEC -> TX_REQ -> TX_WAIT -> IDLE.
- Each frame-byte state advances on an accepted byte.
REQ-018 In IDLE, any non-SYNC byte SHALL be discarded with no response.
REQ-019 In CMD, DHI, DLO or CSUM, a receipt of SYNC SHALL be treated as a data value, not as a resync.
REQ-020 Inter-byte timer:
- Cleared on every accepted byte.
- Runs in CMD, DHI, DLO and CSUM.
- On reaching TIMEOUT_CYCLES, the decoder SHALL return to IDLE with no strobe and no response.
REQ-021 EXEC, good checksum, write: opRegWe SHALL pulse for exactly 1 cycle with the address and data stable, and the response byte SHALL be 8'h06 (ACK).
REQ-022 EXEC, bad checksum: no strobe SHALL be issued, and the response byte SHALL be 8'h15 (NAK).
REQ-023 TX handshake:
- TX_REQ drives opTxData and raises opTxSend.
- When ipTxBusy=1, opTxSend drops and the state moves to TX_WAIT.
- TX_WAIT returns to IDLE (or to the next response byte) when ipTxBusy=0.
- opTxData SHALL stay stable while opTxSend=1.
REQ-024 Bytes arriving during EXEC, TX_REQ or TX_WAIT SHALL be dropped, and no byte SHALL be buffered.
REQ-025 Latency from CSUM acceptance to the opRegWe pulse SHALL be exactly 1 cycle.

Reset
REQ-026 Reset SHALL force the following values, aborting any frame or response in progress, with effect on the next edge:
- State IDLE, timer 0.
- opTxSend=0, opTxData=8'h00.
- opRegWe=0, opRegRe=0.
- opRegAddr=0, opRegWrData=0.
- Edge-detect register=1, so a valid level already high at reset release is not a new byte.

Configuration
REQ-027 With CMD_DECODER_READBACK_EN defined, a good-checksum read SHALL:
- Pulse opRegRe for 1 cycle in EXEC.
- Sample ipRegRdData on the next cycle.
- Transmit three bytes: ACK, rd[15:8], rd[7:0], each through the full TX handshake.
REQ-028 Without CMD_DECODER_READBACK_EN, the opRegRe and ipRegRdData ports SHALL be absent, and a good-checksum read SHALL produce a NAK with no strobe.

Structure
REQ-029 A shared package SHALL hold the state enum and the constants ACK=8'h06, NAK=8'h15 and SYNC default.
REQ-030 One sub-module, uart_tx_handshake, SHALL own the TX_REQ/TX_WAIT sequencing for a single byte.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Frame A5,12,BE,EF,43 -> one opRegWe with addr=7'h12, data=16'hBEEF, then TX byte 06.
- Frame A5,12,BE,EF,44 -> no opRegWe, TX byte 15.
- Bytes 00,7F, then a valid frame -> the leading bytes are ignored and exactly one write occurs.
- A5,12, then a gap of 8680 cycles, then BE,EF,43 -> no write, no response.
- Reset asserted in DLO, then a full valid frame -> exactly one write and one ACK.
- READBACK_EN, frame A5,92,00,00,92 with ipRegRdData=16'h1234 -> opRegRe pulse, TX bytes 06,12,34.

Source files
------------

// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and constants for the UART register-command decoder.
package uart_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DHI,
    ST_DLO,
    ST_CSUM,
    ST_EXEC,
    ST_TX_REQ,
    ST_TX_WAIT
  } dec_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_WAIT
  } hs_state_e;

  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
    return cmd ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/uart_tx_handshake.sv
// Sends one response byte: holds opTxSend until the transmitter reports busy,
// then waits for busy to clear. Data is latched at start so it stays stable.
module uart_tx_handshake
  import uart_cmd_decoder_pkg::*;
(
  input  logic       ipClk,
  input  logic       Reset,
  input  logic       ipStart,
  input  logic [7:0] ipByte,
  input  logic       ipTxBusy,
  output logic [7:0] opTxData,
  output logic       opTxSend,
  output logic       opBusySeen,
  output logic       opDone
);

  hs_state_e  hs_q, hs_d;
  logic [7:0] data_q, data_d;
  logic       send_q, send_d;

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      hs_q   <= HS_IDLE;
      data_q <= 8'h00;
      send_q <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      data_q <= data_d;
      send_q <= send_d;
    end
  end

  always_comb begin
    hs_d   = hs_q;
    data_d = data_q;
    send_d = send_q;
    case (hs_q)
      HS_IDLE: begin
        if (ipStart) begin
          data_d = ipByte;
          send_d = 1'b1;
          hs_d   = HS_REQ;
        end
      end
      HS_REQ: begin
        if (ipTxBusy) begin
          send_d = 1'b0;
          hs_d   = HS_WAIT;
        end
      end
      HS_WAIT: begin
        if (!ipTxBusy) hs_d = HS_IDLE;
      end
      default: hs_d = HS_IDLE;
    endcase
  end

  assign opTxData   = data_q;
  assign opTxSend   = send_q;
  assign opBusySeen = (hs_q == HS_REQ) && ipTxBusy;
  assign opDone     = (hs_q == HS_WAIT) && !ipTxBusy;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes SYNC/CMD/DHI/DLO/CSUM frames into register strobes and ACK/NAK replies.
// Define CMD_DECODER_READBACK_EN to add register reads (opRegRe/ipRegRdData, 3-byte reply).
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 8680
)(
  input  logic        ipClk,
  input  logic        Reset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxSend,
  input  logic        ipTxBusy,
`ifdef CMD_DECODER_READBACK_EN
  output logic        opRegRe,
  input  logic [15:0] ipRegRdData,
`endif
  output logic [6:0]  opRegAddr,
  output logic [15:0] opRegWrData,
  output logic        opRegWe
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  dec_state_e   state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic         rx_prev_q, rx_prev_d;
  logic         byte_vld_q, byte_vld_d;
  logic [7:0]   byte_q, byte_d;
  logic [7:0]   cmd_q, cmd_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [7:0]   resp_q, resp_d;
  logic [1:0]   idx_q, idx_d, last_idx_q, last_idx_d;
  logic         we_q, we_d;
  logic [7:0]   tx_byte;
  logic         hs_start, hs_busy_seen, hs_done;
  logic         csum_ok, timed_out;
`ifdef CMD_DECODER_READBACK_EN
  logic         re_q, re_d, rd_pend_q;
  logic [15:0]  rd_q, rd_d;
`endif

  always_ff @(posedge ipClk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      rx_prev_q  <= 1'b1;  // a level already high at release is not a new byte
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
      cmd_q      <= 8'h00;
      dhi_q      <= 8'h00;
      dlo_q      <= 8'h00;
      resp_q     <= 8'h00;
      idx_q      <= 2'd0;
      last_idx_q <= 2'd0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rx_prev_q  <= rx_prev_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      cmd_q      <= cmd_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      resp_q     <= resp_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      we_q       <= we_d;
    end
  end

`ifdef CMD_DECODER_READBACK_EN
  always_ff @(posedge ipClk) begin
    if (Reset) begin
      re_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_q      <= 16'h0000;
    end else begin
      re_q      <= re_d;
      rd_pend_q <= re_q;
      rd_q      <= rd_d;
    end
  end

  assign rd_d = rd_pend_q ? ipRegRdData : rd_q;
`endif

  assign csum_ok   = (byte_q == frame_csum(cmd_q, dhi_q, dlo_q));
  assign timed_out = (timer_q == TIMER_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    rx_prev_d  = ipRxValid;
    byte_vld_d = ipRxValid && !rx_prev_q;
    byte_d     = (ipRxValid && !rx_prev_q) ? ipRxData : byte_q;
    cmd_d      = cmd_q;
    dhi_d      = dhi_q;
    dlo_d      = dlo_q;
    resp_d     = resp_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    we_d       = 1'b0;
    hs_start   = 1'b0;
`ifdef CMD_DECODER_READBACK_EN
    re_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (byte_vld_q && byte_q == SYNC_BYTE) state_d = ST_CMD;
      end
      ST_CMD, ST_DHI, ST_DLO, ST_CSUM: begin
        timer_d = byte_vld_q ? '0 : timer_q + TIMER_W'(1);
        if (timed_out) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (byte_vld_q) begin
          case (state_q)
            ST_CMD: begin cmd_d = byte_q; state_d = ST_DHI; end
            ST_DHI: begin dhi_d = byte_q; state_d = ST_DLO; end
            ST_DLO: begin dlo_d = byte_q; state_d = ST_CSUM; end
            default: begin
              state_d    = ST_EXEC;
              timer_d    = '0;
              idx_d      = 2'd0;
              last_idx_d = 2'd0;
              resp_d     = NAK_BYTE;
              if (csum_ok && !cmd_q[7]) begin
                we_d   = 1'b1;
                resp_d = ACK_BYTE;
              end
`ifdef CMD_DECODER_READBACK_EN
              if (csum_ok && cmd_q[7]) begin
                re_d       = 1'b1;
                resp_d     = ACK_BYTE;
                last_idx_d = 2'd2;
              end
`endif
            end
          endcase
        end
      end
      ST_EXEC: state_d = ST_TX_REQ;
      ST_TX_REQ: begin
        hs_start = 1'b1;
        if (hs_busy_seen) state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (hs_done) begin
          if (idx_q == last_idx_q) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_TX_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_byte = resp_q;
`ifdef CMD_DECODER_READBACK_EN
    case (idx_q)
      2'd1:    tx_byte = rd_q[15:8];
      2'd2:    tx_byte = rd_q[7:0];
      default: tx_byte = resp_q;
    endcase
`endif
  end

  uart_tx_handshake u_tx_hs (
    .ipClk      (ipClk),
    .Reset      (Reset),
    .ipStart    (hs_start),
    .ipByte     (tx_byte),
    .ipTxBusy   (ipTxBusy),
    .opTxData   (opTxData),
    .opTxSend   (opTxSend),
    .opBusySeen (hs_busy_seen),
    .opDone     (hs_done)
  );

  assign opRegAddr   = cmd_q[6:0];
  assign opRegWrData = {dhi_q, dlo_q};
  assign opRegWe     = we_q;
`ifdef CMD_DECODER_READBACK_EN
  assign opRegRe     = re_q;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with a simple transmitter busy model.
module tb_uart_cmd_decoder;

  logic        ipClk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  ipRxData = 8'h00;
  logic        ipRxValid = 1'b0;
  logic [7:0]  opTxData;
  logic        opTxSend;
  logic        ipTxBusy = 1'b0;
  logic [6:0]  opRegAddr;
  logic [15:0] opRegWrData;
  logic        opRegWe;
`ifdef CMD_DECODER_READBACK_EN
  logic        opRegRe;
  logic [15:0] ipRegRdData = 16'h1234;
`endif

  always #5 ipClk = ~ipClk;

  uart_cmd_decoder dut (
    .ipClk       (ipClk),
    .Reset       (Reset),
    .ipRxData    (ipRxData),
    .ipRxValid   (ipRxValid),
    .opTxData    (opTxData),
    .opTxSend    (opTxSend),
    .ipTxBusy    (ipTxBusy),
`ifdef CMD_DECODER_READBACK_EN
    .opRegRe     (opRegRe),
    .ipRegRdData (ipRegRdData),
`endif
    .opRegAddr   (opRegAddr),
    .opRegWrData (opRegWrData),
    .opRegWe     (opRegWe)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Strobe and TX-stability monitor
  int          we_cnt = 0, re_cnt = 0, we_long = 0, stab_err = 0;
  logic [6:0]  wr_addr = 7'h00;
  logic [15:0] wr_data = 16'h0000;
  logic        prev_we = 1'b0, prev_send = 1'b0;
  logic [7:0]  prev_txd = 8'h00;

  initial begin
    forever begin
      @(negedge ipClk);
      if (opRegWe === 1'b1) begin
        we_cnt++;
        wr_addr = opRegAddr;
        wr_data = opRegWrData;
        if (prev_we) we_long++;
      end
`ifdef CMD_DECODER_READBACK_EN
      if (opRegRe === 1'b1) re_cnt++;
`endif
      if (opTxSend === 1'b1 && prev_send && opTxData !== prev_txd) stab_err++;
      prev_we   = opRegWe;
      prev_send = opTxSend;
      prev_txd  = opTxData;
    end
  end

  // Transmitter model: accepts a byte two cycles after the request, busy for five
  int         tx_cnt = 0;
  logic [7:0] tx_log [0:63];

  initial begin
    forever begin
      @(negedge ipClk);
      if (opTxSend === 1'b1 && !ipTxBusy) begin
        repeat (2) @(negedge ipClk);
        ipTxBusy = 1'b1;
        if (tx_cnt < 64) tx_log[tx_cnt] = opTxData;
        tx_cnt++;
        repeat (5) @(negedge ipClk);
        ipTxBusy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge ipClk);
    ipRxData  = b;
    ipRxValid = 1'b1;
    repeat (3) @(negedge ipClk);
    ipRxValid = 1'b0;
    repeat (2) @(negedge ipClk);
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic settle();
    repeat (120) @(negedge ipClk);
  endtask

  int we0, tx0, re0;

  initial begin
    // Reset with a valid level held high across release
    ipRxData  = 8'hA5;
    ipRxValid = 1'b1;
    repeat (3) @(negedge ipClk);
    check_eq("rst_txsend", opTxSend, 1'b0);
    check_eq("rst_txdata", opTxData, 8'h00);
    check_eq("rst_we",     opRegWe, 1'b0);
    check_eq("rst_addr",   opRegAddr, 7'h00);
    check_eq("rst_wrdata", opRegWrData, 16'h0000);
    Reset = 1'b0;
    repeat (3) @(negedge ipClk);
    ipRxValid = 1'b0;
    repeat (2) @(negedge ipClk);
    we0 = we_cnt; tx0 = tx_cnt;
    send_byte(8'h12); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h43);
    settle();
    check_eq("held_valid_we", we_cnt - we0, 0);
    check_eq("held_valid_tx", tx_cnt - tx0, 0);

    // Good write
    we0 = we_cnt; tx0 = tx_cnt;
    send_frame(40'hA5_12_BE_EF_43);
    settle();
    check_eq("good_we_cnt", we_cnt - we0, 1);
    check_eq("good_addr",   wr_addr, 7'h12);
    check_eq("good_data",   wr_data, 16'hBEEF);
    check_eq("good_tx_cnt", tx_cnt - tx0, 1);
    check_eq("good_tx_ack", tx_log[tx0], 8'h06);

    // Bad checksum
    we0 = we_cnt; tx0 = tx_cnt;
    send_frame(40'hA5_12_BE_EF_44);
    settle();
    check_eq("bad_we_cnt", we_cnt - we0, 0);
    check_eq("bad_tx_cnt", tx_cnt - tx0, 1);
    check_eq("bad_tx_nak", tx_log[tx0], 8'h15);

    // Leading junk in IDLE
    we0 = we_cnt; tx0 = tx_cnt;
    send_byte(8'h00); send_byte(8'h7F);
    send_frame(40'hA5_12_BE_EF_43);
    settle();
    check_eq("junk_we_cnt", we_cnt - we0, 1);
    check_eq("junk_tx_cnt", tx_cnt - tx0, 1);
    check_eq("junk_tx_ack", tx_log[tx0], 8'h06);

    // SYNC value inside the frame is data
    we0 = we_cnt; tx0 = tx_cnt;
    send_frame(40'hA5_12_A5_00_B7);
    settle();
    check_eq("syncdata_we_cnt", we_cnt - we0, 1);
    check_eq("syncdata_data",   wr_data, 16'hA500);
    check_eq("syncdata_tx_ack", tx_log[tx0], 8'h06);

    // Inter-byte timeout
    we0 = we_cnt; tx0 = tx_cnt;
    send_byte(8'hA5); send_byte(8'h12);
    repeat (8680) @(negedge ipClk);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h43);
    settle();
    check_eq("timeout_we_cnt", we_cnt - we0, 0);
    check_eq("timeout_tx_cnt", tx_cnt - tx0, 0);

    // Reset while in DLO, then a full frame
    we0 = we_cnt; tx0 = tx_cnt;
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'hBE);
    @(negedge ipClk);
    Reset = 1'b1;
    repeat (2) @(negedge ipClk);
    check_eq("midrst_addr", opRegAddr, 7'h00);
    Reset = 1'b0;
    send_frame(40'hA5_12_BE_EF_43);
    settle();
    check_eq("midrst_we_cnt", we_cnt - we0, 1);
    check_eq("midrst_tx_cnt", tx_cnt - tx0, 1);
    check_eq("midrst_tx_ack", tx_log[tx0], 8'h06);

    // Good-checksum read
    we0 = we_cnt; tx0 = tx_cnt; re0 = re_cnt;
    send_frame(40'hA5_92_00_00_92);
    settle();
    check_eq("read_we_cnt", we_cnt - we0, 0);
`ifdef CMD_DECODER_READBACK_EN
    check_eq("read_re_cnt", re_cnt - re0, 1);
    check_eq("read_tx_cnt", tx_cnt - tx0, 3);
    check_eq("read_tx0",    tx_log[tx0],     8'h06);
    check_eq("read_tx1",    tx_log[tx0 + 1], 8'h12);
    check_eq("read_tx2",    tx_log[tx0 + 2], 8'h34);
`else
    check_eq("read_tx_cnt", tx_cnt - tx0, 1);
    check_eq("read_tx_nak", tx_log[tx0], 8'h15);
`endif

    check_eq("we_single_cycle", we_long, 0);
    check_eq("txdata_stable",   stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
